// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and emits the
// datapath strobes and mux selects combinationally from the state register
// and the instruction word. It also keeps a sticky illegal-instruction flag
// and a count of retired instructions.
//
// Memory handshake: the control unit holds the access request by staying in
// MEM. mem_ready=1 in a MEM cycle means the memory finishes the access on the
// coming edge, and the FSM leaves MEM on that edge. mem_ready is ignored in
// every other state. For a store, MemWrite stays high on every MEM cycle
// until that edge.
`timescale 1ns/1ps
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        eq,
  input  logic        gtz,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [2:0]  ALUControl,
  output logic [2:0]  EXTControl,
  output logic [2:0]  Mem2Reg,
  output logic [2:0]  NPCControl,
  output logic        ALUSrc,
  output logic [4:0]  RegAddr,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic [31:0] retired_q, retired_d;

  // Instruction fields
  logic [5:0] op, funct;
  logic [4:0] rt, rd;
  logic       unused_fields;

  assign op    = Instr[31:26];
  assign funct = Instr[5:0];
  assign rt    = Instr[20:16];
  assign rd    = Instr[15:11];
  assign unused_fields = ^{Instr[25:21], Instr[10:6]};

  logic is_add, is_sub, is_xor, is_sll, is_jr, is_jalr;
  logic is_ori, is_addi, is_lui, is_lw, is_lb, is_sw;
  logic is_beq, is_bgtz, is_j, is_jal, is_legal;
  logic [2:0] alu_dec, ext_dec, m2r_dec;
  logic       src_dec;
  logic [4:0] ra_dec;

  // Instruction decode: per-instruction flags and the instruction-only selects
  always_comb begin
    is_add  = (op == 6'h00) && (funct == 6'h20);
    is_sub  = (op == 6'h00) && (funct == 6'h22);
    is_xor  = (op == 6'h00) && (funct == 6'h26);
    is_sll  = (op == 6'h00) && (funct == 6'h00);
    is_jr   = (op == 6'h00) && (funct == 6'h08);
    is_jalr = (op == 6'h00) && (funct == 6'h09);
    is_ori  = (op == 6'h0D);
    is_addi = (op == 6'h08);
    is_lui  = (op == 6'h0F);
    is_lw   = (op == 6'h23);
    is_lb   = (op == 6'h20);
    is_sw   = (op == 6'h2B);
    is_beq  = (op == 6'h04);
    is_bgtz = (op == 6'h07);
    is_j    = (op == 6'h02);
    is_jal  = (op == 6'h03);
    is_legal = is_add | is_sub | is_xor | is_sll | is_jr | is_jalr |
               is_ori | is_addi | is_lui | is_lw | is_lb | is_sw |
               is_beq | is_bgtz | is_j | is_jal;

    alu_dec = 3'b000;
    if (is_sub)      alu_dec = 3'b001;
    else if (is_xor) alu_dec = 3'b010;
    else if (is_ori) alu_dec = 3'b011;
    else if (is_sll) alu_dec = 3'b100;

    src_dec = is_ori | is_lw | is_sw | is_lui | is_lb | is_addi;

    ext_dec = 3'b000;
    if (is_lw | is_sw | is_beq | is_bgtz | is_lb | is_addi) ext_dec = 3'b001;
    else if (is_lui)                                        ext_dec = 3'b010;

    m2r_dec = 3'b000;
    if (is_lw)                 m2r_dec = 3'b001;
    else if (is_lui)           m2r_dec = 3'b010;
    else if (is_jal | is_jalr) m2r_dec = 3'b011;
    else if (is_lb)            m2r_dec = 3'b100;

    ra_dec = 5'd0;
    if (is_add | is_sub | is_xor | is_sll | is_jalr)        ra_dec = rd;
    else if (is_ori | is_addi | is_lui | is_lw | is_lb)     ra_dec = rt;
    else if (is_jal)                                        ra_dec = 5'd31;
  end

  // Next-state and control outputs; everything is forced low while reset is held
  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    ALUControl = 3'b000;
    EXTControl = 3'b000;
    Mem2Reg    = 3'b000;
    NPCControl = 3'b000;
    ALUSrc     = 1'b0;
    RegAddr    = 5'd0;

    // The instruction word is only meaningful once it has been latched
    if (state_q != S_FETCH) begin
      ALUControl = alu_dec;
      EXTControl = ext_dec;
      ALUSrc     = src_dec;
    end

    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_j) begin
          PCWrite    = 1'b1;
          NPCControl = 3'b010;
          state_d    = S_FETCH;
        end else if (is_jr) begin
          PCWrite    = 1'b1;
          NPCControl = 3'b100;
          state_d    = S_FETCH;
        end else if (is_jal | is_jalr) begin
          state_d = S_WB;
        end else if (is_legal) begin
          state_d = S_EXEC;
        end else begin
          // Skip the bad word: advance PC sequentially and flag it
          illegal_d  = 1'b1;
          PCWrite    = 1'b1;
          NPCControl = 3'b000;
          state_d    = S_FETCH;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          PCWrite    = 1'b1;
          NPCControl = eq ? 3'b001 : 3'b000;
          state_d    = S_FETCH;
        end else if (is_bgtz) begin
          PCWrite    = 1'b1;
          NPCControl = gtz ? 3'b001 : 3'b000;
          state_d    = S_FETCH;
        end else if (is_lw | is_lb | is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        MemWrite = is_sw;
        if (mem_ready) begin
          if (is_sw) begin
            PCWrite    = 1'b1;
            NPCControl = 3'b000;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        RegAddr  = ra_dec;
        Mem2Reg  = m2r_dec;
        if (is_jal)       NPCControl = 3'b010;
        else if (is_jalr) NPCControl = 3'b100;
        else              NPCControl = 3'b000;
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (!reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      ALUControl = 3'b000;
      EXTControl = 3'b000;
      Mem2Reg    = 3'b000;
      NPCControl = 3'b000;
      ALUSrc     = 1'b0;
      RegAddr    = 5'd0;
    end

    retired_d = retired_q + {31'd0, PCWrite};
  end

  // State, sticky illegal flag and retire counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Each issued instruction pushes its
// hand-computed retire-cycle snapshot into exp_q, and a negedge monitor pops
// and compares it whenever PCWrite=1 (the instruction retires).
// Cycle count = number of cycles from FETCH through the retiring cycle,
// following F, D, E, MEM x (waits+1), WB.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic        eq, gtz, mem_ready;
  logic        PCWrite, IRWrite, RegWrite, MemWrite;
  logic [2:0]  ALUControl, EXTControl, Mem2Reg, NPCControl;
  logic        ALUSrc;
  logic [4:0]  RegAddr;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] retired;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .eq         (eq),
    .gtz        (gtz),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .ALUControl (ALUControl),
    .EXTControl (EXTControl),
    .Mem2Reg    (Mem2Reg),
    .NPCControl (NPCControl),
    .ALUSrc     (ALUSrc),
    .RegAddr    (RegAddr),
    .state      (state),
    .illegal    (illegal),
    .retired    (retired)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  localparam int W = 40;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks;
  int           errors;
  int           model_ret;
  logic         ill_model;
  logic [7:0]   cyc_cnt;

  // {cycles, retired[7:0], illegal, state, NPC, RegWrite, MemWrite, RegAddr, Mem2Reg, ALU, ALUSrc, EXT}
  function automatic logic [W-1:0] pack(input logic [7:0] cyc, input logic [7:0] ret,
                                        input logic ill, input logic [2:0] st,
                                        input logic [2:0] npc, input logic rw,
                                        input logic mw, input logic [4:0] ra,
                                        input logic [2:0] m2r, input logic [2:0] alu,
                                        input logic src, input logic [2:0] ext);
    return {cyc, ret, ill, st, npc, rw, mw, ra, m2r, alu, src, ext};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      if (IRWrite) cyc_cnt = 8'd1;
      else         cyc_cnt = cyc_cnt + 8'd1;
      if (PCWrite) begin
        logic [W-1:0] got, want;
        string nm;
        got = pack(cyc_cnt, retired[7:0], illegal, state, NPCControl, RegWrite, MemWrite,
                   RegAddr, Mem2Reg, ALUControl, ALUSrc, EXTControl);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL retire_unexpected got=%h want=none", got);
        end else begin
          want = exp_q.pop_front();
          nm   = name_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL retire_%s got=%h want=%h", nm, got, want);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called one step after a rising edge with the DUT in FETCH; returns the
  // same way once the instruction has retired.
  task automatic issue(input string name, input logic [31:0] instr, input logic e,
                       input logic g, input int waits, input logic [7:0] cyc,
                       input logic [2:0] st, input logic [2:0] npc, input logic rw,
                       input logic mw, input logic [4:0] ra, input logic [2:0] m2r,
                       input logic [2:0] alu, input logic src, input logic [2:0] ext,
                       input logic bad);
    int  mcnt;
    logic done;
    exp_q.push_back(pack(cyc, model_ret[7:0], ill_model, st, npc, rw, mw, ra, m2r, alu, src, ext));
    name_q.push_back(name);
    model_ret++;
    if (bad) ill_model = 1'b1;
    Instr     = instr;
    eq        = e;
    gtz       = g;
    mem_ready = 1'b0;
    mcnt      = 0;
    done      = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (state == 3'd3) begin
        mem_ready = (mcnt >= waits);
        mcnt++;
      end else begin
        mem_ready = 1'b0;
      end
      @(negedge clk);
      done = PCWrite;
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s got=no_retire want=retire", name);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks    = 0;
    errors    = 0;
    model_ret = 0;
    ill_model = 1'b0;
    cyc_cnt   = 8'd0;
    reset     = 1'b0;
    Instr     = 32'h34011234;
    eq        = 1'b1;
    gtz       = 1'b1;
    mem_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state",   {29'd0, state}, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_strobes", {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
    check("rst_ctrl", {13'd0, ALUControl, EXTControl, Mem2Reg, NPCControl, ALUSrc, RegAddr}, 32'd0);

    @(posedge clk);
    #1;
    eq = 1'b0; gtz = 1'b0; mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("first_fetch_state", {29'd0, state}, 32'd0);
    check("first_fetch_irwrite", {31'd0, IRWrite}, 32'd1);

    //    name    instr         e  g  w  cyc st npc    rw mw ra     m2r     alu     src ext    bad
    issue("ori",  32'h34011234, 0, 0, 0, 4,  4, 3'b000, 1, 0, 5'd1,  3'b000, 3'b011, 1, 3'b000, 0);
    issue("lw3",  32'h8C020004, 0, 0, 3, 8,  4, 3'b000, 1, 0, 5'd2,  3'b001, 3'b000, 1, 3'b001, 0);
    issue("beq1", 32'h10000003, 1, 0, 0, 3,  2, 3'b001, 0, 0, 5'd0,  3'b000, 3'b000, 0, 3'b001, 0);
    issue("beq0", 32'h10000003, 0, 1, 0, 3,  2, 3'b000, 0, 0, 5'd0,  3'b000, 3'b000, 0, 3'b001, 0);
    issue("bgtz1",32'h1C200002, 0, 1, 0, 3,  2, 3'b001, 0, 0, 5'd0,  3'b000, 3'b000, 0, 3'b001, 0);
    issue("bgtz0",32'h1C200002, 1, 0, 0, 3,  2, 3'b000, 0, 0, 5'd0,  3'b000, 3'b000, 0, 3'b001, 0);
    issue("jal",  32'h0C000010, 0, 0, 0, 3,  4, 3'b010, 1, 0, 5'd31, 3'b011, 3'b000, 0, 3'b000, 0);
    issue("add",  32'h00221820, 0, 0, 0, 4,  4, 3'b000, 1, 0, 5'd3,  3'b000, 3'b000, 0, 3'b000, 0);
    issue("sub",  32'h00432022, 0, 0, 0, 4,  4, 3'b000, 1, 0, 5'd4,  3'b000, 3'b001, 0, 3'b000, 0);
    issue("xor",  32'h00A63826, 0, 0, 0, 4,  4, 3'b000, 1, 0, 5'd7,  3'b000, 3'b010, 0, 3'b000, 0);
    issue("sll",  32'h00031080, 0, 0, 0, 4,  4, 3'b000, 1, 0, 5'd2,  3'b000, 3'b100, 0, 3'b000, 0);
    issue("jr",   32'h03E00008, 0, 0, 0, 2,  1, 3'b100, 0, 0, 5'd0,  3'b000, 3'b000, 0, 3'b000, 0);
    issue("jalr", 32'h0020F809, 0, 0, 0, 3,  4, 3'b100, 1, 0, 5'd31, 3'b011, 3'b000, 0, 3'b000, 0);
    issue("j",    32'h08000004, 0, 0, 0, 2,  1, 3'b010, 0, 0, 5'd0,  3'b000, 3'b000, 0, 3'b000, 0);
    issue("addi", 32'h2005FFFF, 0, 0, 0, 4,  4, 3'b000, 1, 0, 5'd5,  3'b000, 3'b000, 1, 3'b001, 0);
    issue("lui",  32'h3C061234, 0, 0, 0, 4,  4, 3'b000, 1, 0, 5'd6,  3'b010, 3'b000, 1, 3'b010, 0);
    issue("lb0",  32'h80070000, 0, 0, 0, 5,  4, 3'b000, 1, 0, 5'd7,  3'b100, 3'b000, 1, 3'b001, 0);
    issue("sw0",  32'hAC020008, 0, 0, 0, 4,  3, 3'b000, 0, 1, 5'd0,  3'b000, 3'b000, 1, 3'b001, 0);
    issue("sw2",  32'hAC020008, 0, 0, 2, 6,  3, 3'b000, 0, 1, 5'd0,  3'b000, 3'b000, 1, 3'b001, 0);
    issue("ill",  32'hFC000000, 0, 0, 0, 2,  1, 3'b000, 0, 0, 5'd0,  3'b000, 3'b000, 0, 3'b000, 1);
    check("illegal_set", {31'd0, illegal}, 32'd1);
    issue("ori2", 32'h34011234, 0, 0, 0, 4,  4, 3'b000, 1, 0, 5'd1,  3'b000, 3'b011, 1, 3'b000, 0);
    issue("illr", 32'h0000003F, 0, 0, 0, 2,  1, 3'b000, 0, 0, 5'd0,  3'b000, 3'b000, 0, 3'b000, 1);
    check("illegal_sticky", {31'd0, illegal}, 32'd1);

    // Store stalled in MEM, then reset asserted mid-cycle
    Instr = 32'hAC020008; eq = 1'b0; gtz = 1'b0; mem_ready = 1'b0;
    for (int c = 0; c < 8 && state != 3'd3; c++) begin
      @(posedge clk);
      #1;
    end
    check("abort_reached_mem", {29'd0, state}, 32'd3);
    repeat (2) @(posedge clk);
    #1;
    check("abort_memwrite_before", {31'd0, MemWrite}, 32'd1);
    check("abort_pcwrite_stall", {31'd0, PCWrite}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("abort_memwrite", {31'd0, MemWrite}, 32'd0);
    check("abort_state", {29'd0, state}, 32'd0);
    check("abort_retired", retired, 32'd0);
    check("abort_illegal", {31'd0, illegal}, 32'd0);
    check("abort_strobes", {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
    @(posedge clk);
    #1;
    check("abort_no_edge_state", {29'd0, state}, 32'd0);
    reset = 1'b1;
    model_ret = 0;
    ill_model = 1'b0;
    #1;
    check("rerelease_irwrite", {31'd0, IRWrite}, 32'd1);
    issue("ori3", 32'h34011234, 0, 0, 0, 4,  4, 3'b000, 1, 0, 5'd1,  3'b000, 3'b011, 1, 3'b000, 0);
    check("retired_after", retired, 32'd1);

    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
